inv_mix_columns_seq: RTL



---
 rtl/inv_mix_columns_seq.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: captures a 128-bit state, transforms one column per clock.
// Define INV_MIX_FWD_EN to add a 'mode' port selecting forward MixColumns (mode=1).
module inv_mix_columns_seq #(
    parameter int NUM_COLS = 4,
    parameter int COL_W    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_COLS*COL_W-1:0] state_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_COLS*COL_W-1:0] state_out,
    output logic                      busy
`ifdef INV_MIX_FWD_EN
    ,
    input  logic                      mode
`endif
);

    localparam int CNT_W = $clog2(NUM_COLS);
    localparam int ST_W  = NUM_COLS * COL_W;

    generate
        if (NUM_COLS != 4 || COL_W != 32) begin : g_bad_param
            $error("inv_mix_columns_seq supports only NUM_COLS=4, COL_W=32");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   col_cnt_q;
    logic [ST_W-1:0]    work_q;
    logic [ST_W-1:0]    work_d;
    logic [COL_W-1:0]   cur_col;
    logic [COL_W-1:0]   col_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
`ifdef INV_MIX_FWD_EN
    logic               mode_q;
`endif

    // GF(2^8) doubling modulo x^8+x^4+x^3+x+1; every product stays 8 bits wide.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    function automatic logic [COL_W-1:0] inv_col(input logic [COL_W-1:0] c);
        logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
        a0 = c[7:0];
        a1 = c[15:8];
        a2 = c[23:16];
        a3 = c[31:24];
        b0 = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
        b1 = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
        b2 = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
        b3 = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
        return {b3, b2, b1, b0};
    endfunction

`ifdef INV_MIX_FWD_EN
    function automatic logic [COL_W-1:0] fwd_col(input logic [COL_W-1:0] c);
        logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
        a0 = c[7:0];
        a1 = c[15:8];
        a2 = c[23:16];
        a3 = c[31:24];
        b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {b3, b2, b1, b0};
    endfunction
`endif

    always_comb begin
        cur_col = work_q[int'(col_cnt_q)*COL_W +: COL_W];
`ifdef INV_MIX_FWD_EN
        col_d = mode_q ? fwd_col(cur_col) : inv_col(cur_col);
`else
        col_d = inv_col(cur_col);
`endif
        work_d = work_q;
        work_d[int'(col_cnt_q)*COL_W +: COL_W] = col_d;
    end

    // Control and outputs are all registered so nothing downstream sees a combinational path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            col_cnt_q   <= '0;
            work_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef INV_MIX_FWD_EN
            mode_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q     <= state_in;
                        col_cnt_q  <= '0;
                        state_q    <= BUSY;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef INV_MIX_FWD_EN
                        mode_q     <= mode;
`endif
                    end
                end
                BUSY: begin
                    work_q    <= work_d;
                    col_cnt_q <= col_cnt_q + 1'b1;
                    if (col_cnt_q == CNT_W'(NUM_COLS - 1)) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    col_cnt_q   <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign state_out = work_q;

endmodule
